// File: rtl/fifo_uart_pkg.sv
// Shared constants for the FIFO-draining UART transmitter: state codes,
// default geometry and a frame-length helper (PARITY_EN adds one bit-time).
package fifo_uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 16;
  localparam int DATA_W_DEF       = 8;
  localparam int STATE_W          = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_LOAD   = 3'd1;
  localparam logic [STATE_W-1:0] ST_START  = 3'd2;
  localparam logic [STATE_W-1:0] ST_DATA   = 3'd3;
  localparam logic [STATE_W-1:0] ST_PARITY = 3'd4;
  localparam logic [STATE_W-1:0] ST_STOP   = 3'd5;

  // Clock cycles from one start bit to the next when bytes are back to back,
  // including the single LOAD cycle between frames.
  function automatic int frame_cycles(input int clks_per_bit, input int data_w,
                                      input bit parity_en);
    return (2 + data_w + (parity_en ? 1 : 0)) * clks_per_bit + 1;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_tick.sv
// Bit-time divider: counts CLKS_PER_BIT cycles after every synchronous clear
// and pulses tick on the last cycle of each bit-time.
module baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt;

  // Sequence after a clear is 0, N-1, ..., 1, so the value 1 marks the last cycle.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      cnt <= '0;
    end else if (cnt == '0) begin
      cnt <= CW'(CLKS_PER_BIT - 1);
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == CW'(1));

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the byte FIFO onto a UART line, LSB first, 8N1 by default.
// Define PARITY_EN to add an even-parity bit (8E1 frame).
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_W       = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic              tx,
  output logic              busy,
  output logic              tx_done,
  output logic [2:0]        fsm_state
);

  // Handshake: fifo_rd is a one-cycle pop strobe, raised only in LOAD, which is
  // entered only after fifo_empty=0 was sampled; fifo_data is taken at its end.

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [DATA_W-1:0] shift_q;
  logic [BW-1:0]     bit_cnt;
  logic              bit_end;
  logic              last_bit;
  logic              baud_clear;
  logic              tx_nxt;
`ifdef PARITY_EN
  logic              parity_q;
`endif

  assign last_bit   = (bit_cnt == BW'(DATA_W - 1));
  assign baud_clear = (state_nxt != state);
  assign fsm_state  = state;

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk  (clk),
    .reset(reset),
    .clear(baud_clear),
    .tick (bit_end)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!fifo_empty) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_START;
      ST_START: if (bit_end) state_nxt = ST_DATA;
      ST_DATA: begin
        if (bit_end && last_bit) begin
`ifdef PARITY_EN
          state_nxt = ST_PARITY;
`else
          state_nxt = ST_STOP;
`endif
        end
      end
`ifdef PARITY_EN
      ST_PARITY: if (bit_end) state_nxt = ST_STOP;
`endif
      ST_STOP: if (bit_end) state_nxt = fifo_empty ? ST_IDLE : ST_LOAD;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The line level is registered from the current state, so tx trails the
  // state by one cycle and the start bit appears one edge after LOAD ends.
  always_comb begin
    tx_nxt = 1'b1;
    case (state)
      ST_START:  tx_nxt = 1'b0;
      ST_DATA:   tx_nxt = shift_q[0];
`ifdef PARITY_EN
      ST_PARITY: tx_nxt = parity_q;
`endif
      default:   tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      shift_q <= '0;
      bit_cnt <= '0;
      fifo_rd <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      fifo_rd <= (state_nxt == ST_LOAD);
      busy    <= (state_nxt != ST_IDLE);
      tx      <= tx_nxt;
      tx_done <= (state == ST_STOP) && bit_end;
      if (state == ST_LOAD) begin
        shift_q <= fifo_data;
        bit_cnt <= '0;
      end else if ((state == ST_DATA) && bit_end) begin
        shift_q <= shift_q >> 1;
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

`ifdef PARITY_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      parity_q <= 1'b0;
    end else if (state == ST_LOAD) begin
      parity_q <= ^fifo_data;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model, UART line decoder with expected-frame
// scoreboard, table-driven byte vectors and hand-written corner sequences.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int DW  = 8;
`ifdef PARITY_EN
  localparam int NSLOT = 11;
`else
  localparam int NSLOT = 10;
`endif
  localparam int FRAME_LEN = NSLOT * CPB;
  localparam int FW        = 11;

  typedef struct {
    logic [7:0] data;
    logic [9:0] slots;
    logic       par;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_rd;
  logic          tx;
  logic          busy;
  logic          tx_done;
  logic [2:0]    fsm_state;

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_W      (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd   (fifo_rd),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]    fifo_q[$];
  logic [FW-1:0] exp_q[$];
  int            gaps_q[$];

  int cyc = 0, last_start = 0;
  int rd_pulses = 0, rd_long = 0, underflow = 0;
  int done_cnt = 0, stray_done = 0, unexpected = 0, tx_low = 0;
  logic rd_prev = 1'b0, tx_prev = 1'b1, mon_active = 1'b0, frame_err = 1'b0;
  int mon_j = 0;
  logic [FW-1:0] cur_frame = '0, got = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [FW-1:0] make_frame(input logic [7:0] d);
`ifdef PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {2'b01, d, 1'b0};
`endif
  endfunction

  task automatic refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endtask

  task automatic push_byte(input logic [7:0] d, input logic [FW-1:0] f);
    fifo_q.push_back(d);
    exp_q.push_back(f);
    refresh();
  endtask

  // One clock: FIFO pop model, strobe bookkeeping and the line decoder.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (rd_prev && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (fifo_rd && rd_prev) rd_long++;
    if (fifo_rd && !rd_prev) begin
      rd_pulses++;
      if (fifo_q.size() == 0) underflow++;
    end
    rd_prev = fifo_rd;
    if (!tx) tx_low++;
    if (tx_done) done_cnt++;
    if (!mon_active) begin
      if (tx_done) stray_done++;
      if (!tx && tx_prev) begin
        mon_active = 1'b1;
        mon_j      = 0;
        frame_err  = 1'b0;
        got        = '0;
        gaps_q.push_back(cyc - last_start);
        last_start = cyc;
        if (exp_q.size() == 0) begin
          unexpected++;
          cur_frame = '0;
        end else begin
          cur_frame = exp_q.pop_front();
        end
      end
    end
    if (mon_active) begin
      if (mon_j % CPB == CPB / 2) got[mon_j / CPB] = tx;
      if (tx !== cur_frame[mon_j / CPB]) frame_err = 1'b1;
      if (tx_done !== (mon_j == FRAME_LEN - 1)) frame_err = 1'b1;
      if ((mon_j < FRAME_LEN - 1) && !busy) frame_err = 1'b1;
      if (mon_j == FRAME_LEN - 1) begin
        check("frame_bits", 32'(got), 32'(cur_frame));
        check("frame_timing", 32'(frame_err), 32'd0);
        mon_active = 1'b0;
      end
      mon_j++;
    end
    tx_prev = tx;
    refresh();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((mon_active || exp_q.size() != 0 || fifo_q.size() != 0 || busy) && n < 3000) begin
      step();
      n++;
    end
    check({name, "_drain"}, 32'(n < 3000), 32'd1);
  endtask

  initial begin
    vec_t vecs [8];
    int rd0, d0, t0, n;
    logic [FW-1:0] f;
    logic [7:0] rb;

    vecs[0] = '{8'h41, 10'b1_01000001_0, 1'b0};
    vecs[1] = '{8'h43, 10'b1_01000011_0, 1'b1};
    vecs[2] = '{8'h00, 10'b1_00000000_0, 1'b0};
    vecs[3] = '{8'hFF, 10'b1_11111111_0, 1'b0};
    vecs[4] = '{8'h55, 10'b1_01010101_0, 1'b0};
    vecs[5] = '{8'hA5, 10'b1_10100101_0, 1'b0};
    vecs[6] = '{8'h80, 10'b1_10000000_0, 1'b1};
    vecs[7] = '{8'h01, 10'b1_00000001_0, 1'b1};

    reset      = 1'b0;
    fifo_empty = 1'b1;
    fifo_data  = '0;

    // Reset held with a byte waiting in the FIFO.
    push_byte(8'hA5, make_frame(8'hA5));
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_rd", 32'(fifo_rd), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(tx_done), 32'd0);
      check("rst_state", 32'(fsm_state), 32'd0);
    end
    reset = 1'b1;
    wait_idle("first");
    check("first_rd_count", 32'(rd_pulses), 32'd1);

    // Latency from fifo_empty falling to the start bit.
    rd0 = rd_pulses;
    push_byte(8'h3C, make_frame(8'h3C));
    step();
    check("lat_rd_n", 32'(fifo_rd), 32'd1);
    check("lat_tx_n", 32'(tx), 32'd1);
    check("lat_busy_n", 32'(busy), 32'd1);
    step();
    check("lat_rd_n1", 32'(fifo_rd), 32'd0);
    check("lat_tx_n1", 32'(tx), 32'd1);
    step();
    check("lat_tx_n2", 32'(tx), 32'd0);
    wait_idle("latency");
    check("lat_rd_count", 32'(rd_pulses - rd0), 32'd1);

    // Single bytes from the vector table.
    for (int i = 0; i < 8; i++) begin
      rd0 = rd_pulses;
      d0  = done_cnt;
`ifdef PARITY_EN
      f = {1'b1, vecs[i].par, vecs[i].slots[8:0]};
`else
      f = {1'b0, vecs[i].slots};
`endif
      push_byte(vecs[i].data, f);
      wait_idle("vec");
      check("vec_rd_count", 32'(rd_pulses - rd0), 32'd1);
      check("vec_done_count", 32'(done_cnt - d0), 32'd1);
      check("vec_idle_tx", 32'(tx), 32'd1);
    end

    // Four preloaded bytes sent back to back.
    gaps_q.delete();
    rd0 = rd_pulses;
    d0  = done_cnt;
    push_byte(8'h40, make_frame(8'h40));
    push_byte(8'h40, make_frame(8'h40));
    push_byte(8'h41, make_frame(8'h41));
    push_byte(8'h42, make_frame(8'h42));
    wait_idle("b2b");
    check("b2b_rd_count", 32'(rd_pulses - rd0), 32'd4);
    check("b2b_done_count", 32'(done_cnt - d0), 32'd4);
    check("b2b_frames", 32'(gaps_q.size()), 32'd4);
    for (int i = 1; i < gaps_q.size(); i++) check("b2b_gap", 32'(gaps_q[i]), 32'(FRAME_LEN + 1));

    // Random bytes, also back to back.
    rd0 = rd_pulses;
    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom_range(0, 255));
      push_byte(rb, make_frame(rb));
    end
    wait_idle("rand");
    check("rand_rd_count", 32'(rd_pulses - rd0), 32'd4);

    // A byte arriving mid-frame is picked up at the end of the stop bit.
    gaps_q.delete();
    push_byte(8'h5A, make_frame(8'h5A));
    n = 0;
    while (!(mon_active && mon_j == 10) && n < 500) begin
      step();
      n++;
    end
    check("late_reach", 32'(n < 500), 32'd1);
    push_byte(8'hC3, make_frame(8'hC3));
    wait_idle("late");
    check("late_frames", 32'(gaps_q.size()), 32'd2);
    if (gaps_q.size() == 2) check("late_gap", 32'(gaps_q[1]), 32'(FRAME_LEN + 1));

    // Empty FIFO for 200 cycles.
    rd0 = rd_pulses;
    t0  = tx_low;
    repeat (200) step();
    check("empty_rd", 32'(rd_pulses - rd0), 32'd0);
    check("empty_tx_low", 32'(tx_low - t0), 32'd0);
    check("empty_busy", 32'(busy), 32'd0);

    // Reset pulse during data bit 3 of 0x55; the following byte goes out whole.
    rd0 = rd_pulses;
    d0  = done_cnt;
    push_byte(8'h55, make_frame(8'h55));
    push_byte(8'h96, make_frame(8'h96));
    n = 0;
    while (!(mon_active && mon_j == 4 * CPB + 1) && n < 500) begin
      step();
      n++;
    end
    check("midrst_reach", 32'(n < 500), 32'd1);
    reset = 1'b0;
    step();
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_rd", 32'(fifo_rd), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(tx_done), 32'd0);
    check("midrst_state", 32'(fsm_state), 32'd0);
    mon_active = 1'b0;
    reset = 1'b1;
    wait_idle("midrst");
    check("midrst_rd_count", 32'(rd_pulses - rd0), 32'd2);
    check("midrst_done_count", 32'(done_cnt - d0), 32'd1);

    check("no_underflow", 32'(underflow), 32'd0);
    check("rd_one_cycle", 32'(rd_long), 32'd0);
    check("no_stray_done", 32'(stray_done), 32'd0);
    check("no_unexpected_frame", 32'(unexpected), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
